voice_allocator: RTL and testbench

Scheduler between song_reader and the three note_player voices. Accepts one packed song instruction at a time and steers each note to a free voice, or steals the oldest voice when all three are busy. Services advance (wait) instructions by counting beats before accepting the next instruction. Drives a shared note/duration bus with per-voice one-hot load strobes and tracks voice occupancy from done_with_note pulses.

---
 rtl/voice_allocator.sv | 123 ++++++++++++
 tb/tb_voice_allocator.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Voice scheduler: steers song notes to one of the note_player voices, stealing
// the oldest busy voice when none is free, and counts beats for advance instructions.
module voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int AGE_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_enable,
  input  logic                  beat,
  input  logic                  note_in_valid,
  input  logic [15:0]           note_in,
  output logic                  note_in_ready,
  output logic                  note_done,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [5:0]            voice_note,
  output logic [5:0]            voice_duration,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic                  stolen
);

  localparam int VW = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state_q;
  logic [5:0]            cnt_q;
  logic [AGE_WIDTH-1:0]  age_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] busy_q;
  logic [NUM_VOICES-1:0] load_q;
  logic                  done_q;
  logic                  stolen_q;
  logic [5:0]            note_q;
  logic [5:0]            dur_q;
  logic [VW-1:0]         victim;
  logic                  found;

  // Lowest free voice first; otherwise the oldest busy voice, ties to lowest index.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!found && !busy_q[i]) begin
        victim = VW'(i);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned i = 1; i < NUM_VOICES; i++) begin
        if (age_q[i] > age_q[victim]) victim = VW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= '0;
      load_q   <= '0;
      done_q   <= 1'b0;
      stolen_q <= 1'b0;
      note_q   <= '0;
      dur_q    <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
    end else begin
      load_q   <= '0;
      done_q   <= 1'b0;
      stolen_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (load_q[i])          busy_q[i] <= 1'b1;
        else if (voice_done[i]) busy_q[i] <= 1'b0;
        if (load_q[i] || !busy_q[i]) age_q[i] <= '0;
        else if ((|load_q) && (age_q[i] != '1)) age_q[i] <= age_q[i] + AGE_WIDTH'(1);
      end
      case (state_q)
        IDLE: begin
          if (play_enable && note_in_valid) begin
            if (note_in[15]) begin
              if (note_in[8:3] == 6'd0) begin
                done_q  <= 1'b1;
                state_q <= ISSUE;
              end else begin
                cnt_q   <= note_in[8:3];
                state_q <= WAIT;
              end
            end else begin
              done_q  <= 1'b1;
              state_q <= ISSUE;
              if (note_in[14:9] != 6'd0) begin
                load_q   <= NUM_VOICES'(1) << victim;
                stolen_q <= busy_q[victim];
                note_q   <= note_in[14:9];
                dur_q    <= note_in[8:3];
              end
            end
          end
        end
        ISSUE: state_q <= IDLE;
        WAIT: begin
          if (play_enable && beat) begin
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
              done_q  <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign note_in_ready  = (state_q == IDLE) & play_enable;
  assign note_done      = done_q;
  assign voice_load     = load_q;
  assign voice_note     = note_q;
  assign voice_duration = dur_q;
  assign voice_busy     = busy_q;
  assign stolen         = stolen_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios then random traffic,
// compared each cycle against a behavioural model of the scheduling rules.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        reset, play_enable, beat, note_in_valid;
  logic [15:0] note_in;
  logic        note_in_ready, note_done, stolen;
  logic [2:0]  voice_done, voice_load, voice_busy;
  logic [5:0]  voice_note, voice_duration;

  voice_allocator #(.NUM_VOICES(3), .AGE_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .beat(beat),
    .note_in_valid(note_in_valid), .note_in(note_in), .note_in_ready(note_in_ready),
    .note_done(note_done), .voice_done(voice_done), .voice_load(voice_load),
    .voice_note(voice_note), .voice_duration(voice_duration),
    .voice_busy(voice_busy), .stolen(stolen)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Model: mode 0 = ready for instructions, 1 = finishing an instruction, 2 = counting beats.
  int       m_mode = 0;
  int       m_beats = 0;
  int       loads_since [3];
  bit [2:0] m_busy = '0;
  bit [2:0] e_load = '0;
  bit       e_done = 1'b0;
  bit       e_stolen = 1'b0;
  bit [5:0] e_note = '0;
  bit [5:0] e_dur = '0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk_note(input int v, input int d);
    logic [5:0] vv, dd;
    vv = 6'(v);
    dd = 6'(d);
    return {1'b0, vv, dd, 3'b000};
  endfunction

  function automatic logic [15:0] mk_adv(input int d);
    logic [5:0] dd;
    dd = 6'(d);
    return {1'b1, 6'd0, dd, 3'b000};
  endfunction

  function automatic int pick_voice();
    int best = 0;
    for (int i = 0; i < 3; i++) if (!m_busy[i]) return i;
    for (int i = 1; i < 3; i++)
      if ((loads_since[i] > 3 ? 3 : loads_since[i]) > (loads_since[best] > 3 ? 3 : loads_since[best]))
        best = i;
    return best;
  endfunction

  task automatic model_next(input bit rst, input bit pl, input bit bt, input bit vl,
                            input logic [15:0] ni, input logic [2:0] vd);
    bit [2:0] nb;
    int v;
    if (rst) begin
      m_mode = 0; m_beats = 0; m_busy = '0; e_load = '0; e_done = 0; e_stolen = 0;
      e_note = '0; e_dur = '0;
      for (int i = 0; i < 3; i++) loads_since[i] = 0;
      return;
    end
    v = pick_voice();
    nb = m_busy;
    for (int i = 0; i < 3; i++) begin
      if (e_load[i]) nb[i] = 1'b1;
      else if (vd[i]) nb[i] = 1'b0;
      if (e_load[i] || !m_busy[i]) loads_since[i] = 0;
      else if (e_load != 0) loads_since[i]++;
    end
    e_load = '0; e_done = 0; e_stolen = 0;
    case (m_mode)
      0: if (pl && vl) begin
        if (ni[15] && ni[8:3] != 0) begin
          m_beats = int'(ni[8:3]);
          m_mode = 2;
        end else begin
          e_done = 1; m_mode = 1;
          if (!ni[15] && ni[14:9] != 0) begin
            e_load = 3'(1 << v);
            e_stolen = m_busy[v];
            e_note = ni[14:9];
            e_dur = ni[8:3];
          end
        end
      end
      1: m_mode = 0;
      default: if (pl && bt) begin
        m_beats--;
        if (m_beats == 0) begin e_done = 1; m_mode = 1; end
      end
    endcase
    m_busy = nb;
  endtask

  task automatic step(input bit rst, input bit pl, input bit bt, input bit vl,
                      input logic [15:0] ni, input logic [2:0] vd);
    reset = rst; play_enable = pl; beat = bt; note_in_valid = vl; note_in = ni; voice_done = vd;
    #1;
    check("ready", note_in_ready, (m_mode == 0 && pl));
    model_next(rst, pl, bt, vl, ni, vd);
    @(negedge clk);
    check("load", voice_load, e_load);
    check("done", note_done, e_done);
    check("stolen", stolen, e_stolen);
    check("busy", voice_busy, m_busy);
    check("note", voice_note, e_note);
    check("dur", voice_duration, e_dur);
  endtask

  initial begin
    logic [15:0] ni;
    logic [2:0]  vd;
    for (int i = 0; i < 3; i++) loads_since[i] = 0;
    reset = 1; play_enable = 0; beat = 0; note_in_valid = 0; note_in = '0; voice_done = '0;
    @(negedge clk);
    step(1, 1, 0, 0, '0, '0);
    step(0, 1, 0, 1, mk_note(20, 8), '0);
    step(0, 1, 0, 0, '0, '0);
    step(0, 1, 0, 0, '0, '0);
    step(1, 1, 0, 0, '0, '0);
    for (int n = 10; n <= 14; n++) begin
      step(0, 1, 0, 1, mk_note(n, n - 5), '0);
      step(0, 1, 0, 0, '0, '0);
    end
    step(0, 1, 0, 0, '0, 3'b010);
    step(0, 1, 0, 1, mk_note(15, 2), '0);
    step(0, 1, 0, 0, '0, 3'b010);
    step(0, 1, 0, 0, '0, '0);
    step(0, 1, 0, 1, mk_adv(3), '0);
    step(0, 1, 1, 0, '0, '0);
    step(0, 1, 0, 0, '0, '0);
    step(0, 0, 1, 0, '0, '0);
    step(0, 0, 1, 0, '0, '0);
    step(0, 1, 1, 0, '0, '0);
    step(0, 1, 1, 0, '0, '0);
    step(0, 1, 0, 0, '0, '0);
    step(0, 1, 0, 1, mk_note(0, 4), '0);
    step(0, 1, 0, 0, '0, '0);
    step(0, 1, 0, 1, mk_adv(0), '0);
    step(0, 1, 0, 0, '0, '0);
    step(0, 1, 0, 1, mk_adv(5), '0);
    step(0, 1, 1, 0, '0, '0);
    step(1, 1, 1, 0, '0, '0);
    step(0, 1, 0, 0, '0, '0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0)
        ni = mk_adv($urandom_range(0, 4));
      else
        ni = mk_note(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63), $urandom_range(0, 63));
      for (int b = 0; b < 3; b++) vd[b] = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, ni, vd);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
